fifo_ptr_ctrl: RTL and testbench

Single-clock FIFO pointer controller for the accelerator's on-chip buffers, generalising the existing per-side pointer block into one unit that owns both write and read pointers. Supports any depth ≥ 2, not only powers of two, with lap-bit wrap handling. Provides registered full/empty, programmable almost-full/almost-empty and an occupancy level. Drives the address ports of an external dual-port RAM; the block holds no data storage.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/wrap_counter.sv | 46 ++++
 rtl/fifo_ptr_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared types, width helper and reset constants for the FIFO
//            pointer controller and its wrap counters.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Address width for a given depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // The four registered status flags, kept together so they reset as a unit.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Status after reset or clear: empty FIFO, so only the "empty" flags are up.
  localparam fifo_status_t c_status_rst = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  // Sticky error flags start low.
  localparam logic c_err_rst = 1'b0;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module   : wrap_counter
// Brief    : Modulo-Depth pointer (0..Depth-1) with a lap bit that toggles
//            on every wrap. Depth need not be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module wrap_counter
  import fifo_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       inc_i,
  input  logic                       clr_i,
  output logic [ptr_w(Depth)-1:0]    count_o,
  output logic                       lap_o
);

  localparam int              CntW   = ptr_w(Depth);
  localparam logic [CntW-1:0] c_last = CntW'(Depth - 1);

  logic [CntW-1:0] r_count;
  logic            r_lap;

  // Advance on increment; at the last slot return to 0 and flip the lap bit.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_count <= '0;
      r_lap   <= 1'b0;
    end else if (inc_i) begin
      if (r_count == c_last) begin
        r_count <= '0;
        r_lap   <= ~r_lap;
      end else begin
        r_count <= r_count + CntW'(1);
      end
    end
  end

  assign count_o = r_count;
  assign lap_o   = r_lap;

endmodule
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_ctrl
// Brief    : Single-clock FIFO pointer controller for an external dual-port
//            RAM. Owns write/read pointers (any Depth >= 2, lap-bit wrap),
//            occupancy level and registered full/empty/almost flags.
//            Optional sticky overflow/underflow flags are built when the
//            macro FIFO_PTR_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int Depth        = 8,
  parameter  int AfullThresh  = Depth - 2,
  parameter  int AemptyThresh = 2,
  localparam int AddrW        = ptr_w(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             wr_req_i,
  input  logic             rd_req_i,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [AddrW-1:0] wr_addr_o,
  output logic [AddrW-1:0] rd_addr_o,
  output logic [AddrW:0]   level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
`ifdef FIFO_PTR_ERR_EN
  ,
  output logic             overflow_o,
  output logic             underflow_o
`endif
);

  localparam int              LvlW     = AddrW + 1;
  localparam logic [LvlW-1:0] c_depth  = LvlW'(Depth);
  localparam logic [LvlW-1:0] c_afull  = LvlW'(AfullThresh);
  localparam logic [LvlW-1:0] c_aempty = LvlW'(AemptyThresh);

  // Reject illegal configurations at elaboration time.
  generate
    if ((Depth < 2) || (AemptyThresh < 0) || (AemptyThresh >= AfullThresh) ||
        (AfullThresh > Depth)) begin : g_bad_params
      $error("fifo_ptr_ctrl: need Depth>=2 and 0<=AemptyThresh<AfullThresh<=Depth");
    end
  endgenerate

  logic [AddrW-1:0] w_wr_ptr;
  logic [AddrW-1:0] w_rd_ptr;
  logic             w_wr_lap;
  logic             w_rd_lap;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [LvlW-1:0]  w_level;
  logic [LvlW-1:0]  w_level_nxt;
  fifo_status_t     r_status;
  fifo_status_t     w_status_nxt;

  // Acceptance uses the registered flags; reset and clear discard requests.
  assign w_wr_en = wr_req_i & ~r_status.full  & ~clear_i & ~rst_i;
  assign w_rd_en = rd_req_i & ~r_status.empty & ~clear_i & ~rst_i;

  wrap_counter #(
    .Depth (Depth)
  ) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_wr_en),
    .clr_i   (clear_i),
    .count_o (w_wr_ptr),
    .lap_o   (w_wr_lap)
  );

  wrap_counter #(
    .Depth (Depth)
  ) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_rd_en),
    .clr_i   (clear_i),
    .count_o (w_rd_ptr),
    .lap_o   (w_rd_lap)
  );

  // Occupancy is the lap-corrected pointer distance, so the level can never
  // drift from the pointers. Modular LvlW arithmetic keeps Depth+wr-rd exact.
  always_comb begin
    w_level = {1'b0, w_wr_ptr} - {1'b0, w_rd_ptr};
    if (w_wr_lap != w_rd_lap) begin
      w_level = c_depth + {1'b0, w_wr_ptr} - {1'b0, w_rd_ptr};
    end
  end

  // Next-state level: +1 write only, -1 read only, hold otherwise.
  always_comb begin
    w_level_nxt = w_level;
    if (w_wr_en && !w_rd_en) begin
      w_level_nxt = w_level + LvlW'(1);
    end else if (!w_wr_en && w_rd_en) begin
      w_level_nxt = w_level - LvlW'(1);
    end
  end

  // Flags are decoded from the next-state level so they register in step
  // with the pointers.
  always_comb begin
    w_status_nxt              = c_status_rst;
    w_status_nxt.full         = (w_level_nxt == c_depth);
    w_status_nxt.empty        = (w_level_nxt == '0);
    w_status_nxt.almost_full  = (w_level_nxt >= c_afull);
    w_status_nxt.almost_empty = (w_level_nxt <= c_aempty);
  end

  // Status register; reset and clear both return to the empty state.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_status <= c_status_rst;
    end else begin
      r_status <= w_status_nxt;
    end
  end

`ifdef FIFO_PTR_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error capture of refused requests; cleared only by reset or clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_overflow  <= c_err_rst;
      r_underflow <= c_err_rst;
    end else begin
      if (wr_req_i && r_status.full) begin
        r_overflow <= 1'b1;
      end
      if (rd_req_i && r_status.empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;
`endif

  assign wr_en_o        = w_wr_en;
  assign rd_en_o        = w_rd_en;
  assign wr_addr_o      = w_wr_ptr;
  assign rd_addr_o      = w_rd_ptr;
  assign level_o        = w_level;
  assign full_o         = r_status.full;
  assign empty_o        = r_status.empty;
  assign almost_full_o  = r_status.almost_full;
  assign almost_empty_o = r_status.almost_empty;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ptr_ctrl
// Brief    : Self-checking bench for fifo_ptr_ctrl. One Depth=8 instance for
//            fill/full/empty/clear/error/random scenarios and one Depth=6
//            instance for non-power-of-two wrap. Error-flag checks are built
//            when FIFO_PTR_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ptr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr8, rd8, clr8, wen8, ren8, full8, empty8, af8, ae8;
  logic [2:0] wa8, ra8;
  logic [3:0] lvl8;
  logic       wr6, rd6, clr6, wen6, ren6, full6, empty6, af6, ae6;
  logic [2:0] wa6, ra6;
  logic [3:0] lvl6;
`ifdef FIFO_PTR_ERR_EN
  logic       ovf8, unf8, ovf6, unf6;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_ptr_ctrl #(.Depth(8)) dut8 (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clr8),
    .wr_req_i       (wr8),
    .rd_req_i       (rd8),
    .wr_en_o        (wen8),
    .rd_en_o        (ren8),
    .wr_addr_o      (wa8),
    .rd_addr_o      (ra8),
    .level_o        (lvl8),
    .full_o         (full8),
    .empty_o        (empty8),
    .almost_full_o  (af8),
    .almost_empty_o (ae8)
`ifdef FIFO_PTR_ERR_EN
    ,
    .overflow_o     (ovf8),
    .underflow_o    (unf8)
`endif
  );

  fifo_ptr_ctrl #(.Depth(6)) dut6 (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clr6),
    .wr_req_i       (wr6),
    .rd_req_i       (rd6),
    .wr_en_o        (wen6),
    .rd_en_o        (ren6),
    .wr_addr_o      (wa6),
    .rd_addr_o      (ra6),
    .level_o        (lvl6),
    .full_o         (full6),
    .empty_o        (empty6),
    .almost_full_o  (af6),
    .almost_empty_o (ae6)
`ifdef FIFO_PTR_ERR_EN
    ,
    .overflow_o     (ovf6),
    .underflow_o    (unf6)
`endif
  );

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr8 = 1'b0; wr8 = 1'b1; rd8 = 1'b1;
    clr6 = 1'b0; wr6 = 1'b1; rd6 = 1'b1;
    #1;
    n_checks++;
    if ({wen8, ren8, wen6, ren6} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_enables_t0: got %b want 0000", {wen8, ren8, wen6, ren6});
    end
    step(); step();
    n_checks++;
    if ({wen8, ren8, wen6, ren6} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_enables: got %b want 0000", {wen8, ren8, wen6, ren6});
    end
    rst = 1'b0; wr8 = 1'b0; rd8 = 1'b0; wr6 = 1'b0; rd6 = 1'b0;
    #1;
    n_checks++;
    if ({wa8, ra8, lvl8} !== 10'd0) begin
      n_fail++; $display("FAIL reset_ptr8: got wa=%0d ra=%0d lvl=%0d want 0 0 0", wa8, ra8, lvl8);
    end
    n_checks++;
    if ({full8, empty8, af8, ae8} !== 4'b0101) begin
      n_fail++; $display("FAIL reset_flags8: got %b want 0101", {full8, empty8, af8, ae8});
    end
    n_checks++;
    if ({wa6, ra6, lvl6, full6, empty6, af6, ae6} !== {10'd0, 4'b0101}) begin
      n_fail++; $display("FAIL reset_dut6: got %b want %b",
                         {wa6, ra6, lvl6, full6, empty6, af6, ae6}, {10'd0, 4'b0101});
    end
`ifdef FIFO_PTR_ERR_EN
    n_checks++;
    if ({ovf8, unf8, ovf6, unf6} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_err: got %b want 0000", {ovf8, unf8, ovf6, unf6});
    end
`endif
  endtask

  // Eight writes into an empty Depth=8 FIFO, then a refused ninth.
  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      wr8 = 1'b1;
      #1;
      n_checks++;
      if (wen8 !== 1'b1 || wa8 !== 3'(i) || lvl8 !== 4'(i)) begin
        n_fail++; $display("FAIL fill_step%0d: got wen=%b wa=%0d lvl=%0d want 1 %0d %0d",
                           i, wen8, wa8, lvl8, i, i);
      end
      n_checks++;
      if (af8 !== (i >= 6) || ae8 !== (i <= 2) || full8 !== 1'b0) begin
        n_fail++; $display("FAIL fill_flags%0d: got af=%b ae=%b full=%b want %b %b 0",
                           i, af8, ae8, full8, (i >= 6), (i <= 2));
      end
      step();
    end
    #1;
    n_checks++;
    if ({full8, empty8, af8, ae8} !== 4'b1010 || lvl8 !== 4'd8) begin
      n_fail++; $display("FAIL full_state: got flags=%b lvl=%0d want 1010 8",
                         {full8, empty8, af8, ae8}, lvl8);
    end
    n_checks++;
    if (wen8 !== 1'b0 || wa8 !== 3'd0) begin
      n_fail++; $display("FAIL ninth_write: got wen=%b wa=%0d want 0 0", wen8, wa8);
    end
    step();
    n_checks++;
    if (wa8 !== 3'd0 || lvl8 !== 4'd8) begin
      n_fail++; $display("FAIL ninth_hold: got wa=%0d lvl=%0d want 0 8", wa8, lvl8);
    end
    wr8 = 1'b0;
  endtask

  // Both requests on full, drain, then both requests on empty.
  task automatic test_both_requests();
    wr8 = 1'b1; rd8 = 1'b1;
    #1;
    n_checks++;
    if ({wen8, ren8} !== 2'b01) begin
      n_fail++; $display("FAIL both_on_full_en: got wen,ren=%b want 01", {wen8, ren8});
    end
    step();
    wr8 = 1'b0; rd8 = 1'b0;
    #1;
    n_checks++;
    if (lvl8 !== 4'd7 || ra8 !== 3'd1 || wa8 !== 3'd0 || full8 !== 1'b0) begin
      n_fail++; $display("FAIL both_on_full_state: got lvl=%0d ra=%0d wa=%0d full=%b want 7 1 0 0",
                         lvl8, ra8, wa8, full8);
    end
    rd8 = 1'b1;
    for (int i = 0; i < 7; i++) step();
    #1;
    n_checks++;
    if (lvl8 !== 4'd0 || ra8 !== 3'd0 || empty8 !== 1'b1 || ren8 !== 1'b0) begin
      n_fail++; $display("FAIL drain: got lvl=%0d ra=%0d empty=%b ren=%b want 0 0 1 0",
                         lvl8, ra8, empty8, ren8);
    end
    wr8 = 1'b1;
    #1;
    n_checks++;
    if ({wen8, ren8} !== 2'b10) begin
      n_fail++; $display("FAIL both_on_empty_en: got wen,ren=%b want 10", {wen8, ren8});
    end
    step();
    wr8 = 1'b0; rd8 = 1'b0;
    #1;
    n_checks++;
    if (lvl8 !== 4'd1 || wa8 !== 3'd1 || ra8 !== 3'd0 || {full8, empty8, af8, ae8} !== 4'b0001) begin
      n_fail++; $display("FAIL both_on_empty_state: got lvl=%0d wa=%0d ra=%0d flags=%b want 1 1 0 0001",
                         lvl8, wa8, ra8, {full8, empty8, af8, ae8});
    end
  endtask

  // Level 5, then clear together with both requests.
  task automatic test_clear();
    wr8 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    wr8 = 1'b0;
    #1;
    n_checks++;
    if (lvl8 !== 4'd5 || wa8 !== 3'd5) begin
      n_fail++; $display("FAIL pre_clear: got lvl=%0d wa=%0d want 5 5", lvl8, wa8);
    end
    clr8 = 1'b1; wr8 = 1'b1; rd8 = 1'b1;
    #1;
    n_checks++;
    if ({wen8, ren8} !== 2'b00) begin
      n_fail++; $display("FAIL clear_enables: got wen,ren=%b want 00", {wen8, ren8});
    end
    step();
    clr8 = 1'b0; wr8 = 1'b0; rd8 = 1'b0;
    #1;
    n_checks++;
    if ({wa8, ra8, lvl8} !== 10'd0 || {full8, empty8, af8, ae8} !== 4'b0101) begin
      n_fail++; $display("FAIL clear_state: got wa=%0d ra=%0d lvl=%0d flags=%b want 0 0 0 0101",
                         wa8, ra8, lvl8, {full8, empty8, af8, ae8});
    end
  endtask

  // Depth=6: three writes ahead, then 20 write/read pairs across the 5->0 wrap.
  task automatic test_wrap6();
    int ea;
    int er;
    wr6 = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ea = 3; er = 0;
    rd6 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      n_checks++;
      if ({wen6, ren6} !== 2'b11 || lvl6 !== 4'd3) begin
        n_fail++; $display("FAIL wrap6_lvl%0d: got en=%b lvl=%0d want 11 3", k, {wen6, ren6}, lvl6);
      end
      n_checks++;
      if (full6 !== 1'b0 || empty6 !== 1'b0) begin
        n_fail++; $display("FAIL wrap6_flags%0d: got full=%b empty=%b want 0 0", k, full6, empty6);
      end
      n_checks++;
      if (wa6 !== 3'(ea) || ra6 !== 3'(er)) begin
        n_fail++; $display("FAIL wrap6_addr%0d: got wa=%0d ra=%0d want %0d %0d", k, wa6, ra6, ea, er);
      end
      step();
      ea = (ea + 1) % 6;
      er = (er + 1) % 6;
    end
    wr6 = 1'b0; rd6 = 1'b0;
  endtask

  // Refused reads/writes: no state change, and sticky flags when built.
  task automatic test_err_flags();
    rd8 = 1'b1;
    #1;
    n_checks++;
    if (ren8 !== 1'b0) begin
      n_fail++; $display("FAIL underflow_ren: got %b want 0", ren8);
    end
    step();
    rd8 = 1'b0;
    #1;
    n_checks++;
    if (lvl8 !== 4'd0 || ra8 !== 3'd0 || empty8 !== 1'b1) begin
      n_fail++; $display("FAIL underflow_nochange: got lvl=%0d ra=%0d empty=%b want 0 0 1", lvl8, ra8, empty8);
    end
`ifdef FIFO_PTR_ERR_EN
    n_checks++;
    if ({ovf8, unf8} !== 2'b01) begin
      n_fail++; $display("FAIL underflow_set: got ovf,unf=%b want 01", {ovf8, unf8});
    end
`endif
    wr8 = 1'b1; step(); step(); wr8 = 1'b0;
    rd8 = 1'b1; step(); step(); rd8 = 1'b0;
    #1;
`ifdef FIFO_PTR_ERR_EN
    n_checks++;
    if ({ovf8, unf8} !== 2'b01) begin
      n_fail++; $display("FAIL underflow_sticky: got ovf,unf=%b want 01", {ovf8, unf8});
    end
`endif
    rst = 1'b1; step(); rst = 1'b0;
    #1;
`ifdef FIFO_PTR_ERR_EN
    n_checks++;
    if ({ovf8, unf8} !== 2'b00) begin
      n_fail++; $display("FAIL err_after_rst: got ovf,unf=%b want 00", {ovf8, unf8});
    end
`endif
    wr8 = 1'b1;
    for (int i = 0; i < 9; i++) step();
    wr8 = 1'b0;
    #1;
    n_checks++;
    if (lvl8 !== 4'd8 || wa8 !== 3'd0 || full8 !== 1'b1) begin
      n_fail++; $display("FAIL overflow_nochange: got lvl=%0d wa=%0d full=%b want 8 0 1", lvl8, wa8, full8);
    end
`ifdef FIFO_PTR_ERR_EN
    n_checks++;
    if ({ovf8, unf8} !== 2'b10) begin
      n_fail++; $display("FAIL overflow_set: got ovf,unf=%b want 10", {ovf8, unf8});
    end
`endif
    clr8 = 1'b1; step(); clr8 = 1'b0;
    #1;
    n_checks++;
    if (lvl8 !== 4'd0 || empty8 !== 1'b1) begin
      n_fail++; $display("FAIL err_clear_state: got lvl=%0d empty=%b want 0 1", lvl8, empty8);
    end
`ifdef FIFO_PTR_ERR_EN
    n_checks++;
    if ({ovf8, unf8} !== 2'b00) begin
      n_fail++; $display("FAIL err_after_clear: got ovf,unf=%b want 00", {ovf8, unf8});
    end
`endif
  endtask

  // Random requests and rare clears against a behavioural reference model.
  task automatic test_random();
    int          m_wa;
    int          m_ra;
    int          m_lvl;
    logic        m_ovf;
    logic        m_unf;
    logic        e_wen;
    logic        e_ren;
    logic [15:0] exp_v;
    logic [15:0] got_v;
    m_wa = 0; m_ra = 0; m_lvl = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      wr8  = 1'($urandom_range(0, 1));
      rd8  = 1'($urandom_range(0, 1));
      clr8 = ($urandom_range(0, 255) == 0);
      #1;
      e_wen = wr8 && (m_lvl < 8) && !clr8;
      e_ren = rd8 && (m_lvl > 0) && !clr8;
      exp_v = {e_wen, e_ren, 3'(m_wa), 3'(m_ra), 4'(m_lvl),
               (m_lvl == 8), (m_lvl == 0), (m_lvl >= 6), (m_lvl <= 2)};
      got_v = {wen8, ren8, wa8, ra8, lvl8, full8, empty8, af8, ae8};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL rand_cycle%0d: got %b want %b", c, got_v, exp_v);
      end
`ifdef FIFO_PTR_ERR_EN
      n_checks++;
      if ({ovf8, unf8} !== {m_ovf, m_unf}) begin
        n_fail++; $display("FAIL rand_err%0d: got %b want %b", c, {ovf8, unf8}, {m_ovf, m_unf});
      end
`endif
      if (clr8) begin
        m_wa = 0; m_ra = 0; m_lvl = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        if (wr8 && m_lvl == 8) m_ovf = 1'b1;
        if (rd8 && m_lvl == 0) m_unf = 1'b1;
        if (e_wen) m_wa = (m_wa + 1) % 8;
        if (e_ren) m_ra = (m_ra + 1) % 8;
        m_lvl = m_lvl + (e_wen ? 1 : 0) - (e_ren ? 1 : 0);
      end
      step();
    end
    wr8 = 1'b0; rd8 = 1'b0; clr8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_both_requests();
    test_clear();
    test_wrap6();
    test_err_flags();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
